pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle between stages with a valid/ready handshake, so stages can stall. An optional 2-entry skid buffer removes the combinational ready path. It supports flush with bubble insertion, and keeps a saturating count of transferred beats for debug.

Parameters:
DATA_W, 32, width of data bundle (operands, PC, immediates).
CTRL_W, 16, width of control bundle (ALU op, enables, mem size/sign, etc.).
CTRL_BUBBLE, 0, control value presented whenever the stage holds no valid beat (no-op controls).
SKID, 1, 1 = 2-entry skid buffer with registered In_Ready; 0 = single entry with combinational In_Ready.
CNT_W, 16, width of the beat counter.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
In_Valid  input  1  upstream beat valid
In_Ready  output  1  stage can accept a beat this cycle
In_Ctrl  input  CTRL_W  upstream control bundle
In_Data  input  DATA_W  upstream data bundle
Flush  input  1  synchronous flush; kills all held beats and the incoming beat
Out_Valid  output  1  downstream beat valid
Out_Ready  input  1  downstream accepts
Out_Ctrl  output  CTRL_W  control bundle; equals CTRL_BUBBLE when Out_Valid=0
Out_Data  output  DATA_W  data bundle
Occupancy  output  2  number of held beats (0..2; max 1 when SKID=0)
Beat_Count  output  CNT_W  saturating count of output transfers

Behaviour:
- Clk and Reset naming:
  - one clock, Clk; reset is asynchronous and active-high, Reset.
- Handshake definitions:
  - in_fire = In_Valid & In_Ready.
  - out_fire = Out_Valid & Out_Ready.
  - Out_Valid must not depend combinationally on Out_Ready.
  - Once Out_Valid=1, Out_Ctrl/Out_Data stay stable until out_fire or Flush.
- Reset (async, any time, including mid-transfer):
  - Out_Valid=0, Out_Ctrl=CTRL_BUBBLE, Out_Data=0, Occupancy=0, Beat_Count=0, skid entry cleared.
  - In_Ready = 1 for SKID=1 (register reset value). For SKID=0 it follows its equation.
  - First accept is possible on the first edge after Reset deasserts.
- Latency: 1 cycle from in_fire to Out_Valid. Beats leave in arrival order; none is duplicated or dropped except by Flush.
- SKID=1 state machine (state = Occupancy):
  - EMPTY:
    - in_fire -> main <= input; go ONE.
  - ONE:
    - in_fire & !out_fire -> skid <= input; go TWO.
    - in_fire & out_fire -> main <= input; stay ONE.
    - !in_fire & out_fire -> go EMPTY.
    - otherwise hold.
  - TWO:
    - In_Ready=0.
    - out_fire -> main <= skid; go ONE.
    - otherwise hold.
  - In_Ready is a flop: 1 in EMPTY/ONE, 0 in TWO. It is updated on the same edge as the state.
  - Full throughput: 1 beat/cycle sustained while Out_Ready=1.
- SKID=0:
  - States are EMPTY/ONE only.
  - In_Ready = !Out_Valid | Out_Ready (combinational).
  - in_fire loads main; out_fire without in_fire -> EMPTY.
- Flush (synchronous):
  - Highest priority after Reset.
  - At the edge: Occupancy <= 0, Out_Valid <= 0, skid cleared; the incoming beat is discarded even if in_fire.
  - If out_fire coincides with Flush, that beat counts as transferred (Beat_Count increments); downstream owns it.
  - Out_Data is retained, not zeroed. Out_Ctrl shows CTRL_BUBBLE.
  - For SKID=1, In_Ready is 1 the cycle after Flush.
- Bubble rule: Out_Ctrl = Out_Valid ? held_ctrl : CTRL_BUBBLE, in every cycle, so downstream enables are inert when empty.
- Beat_Count:
  - +1 on each out_fire.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by Reset, not by Flush.
- Ready/valid are fully independent inputs. In_Valid may drop without a transfer; the stage must tolerate it.

Test Plan:
- Reset mid-stream: SKID=1, hold 2 beats (Occupancy=2), assert Reset asynchronously between edges -> immediately Out_Valid=0, Out_Ctrl=0, Occupancy=0, Beat_Count=0, In_Ready=1.
- Streaming: Out_Ready=1, In_Ctrl=0x0001..0x0008 / In_Data=0x100..0x107 on 8 consecutive cycles -> the same 8 beats appear in order one cycle later, Beat_Count=8, In_Ready never drops.
- Backpressure/skid: send beat A (Data=0xA), then B (Data=0xB) with Out_Ready=0 -> Occupancy=2, In_Ready=0 next cycle, Out_Data=0xA held. Raise Out_Ready -> A then B delivered on consecutive cycles, Occupancy returns to 0.
- Flush with simultaneous input: Occupancy=2, In_Valid=1, Out_Ready=0, Flush=1 -> next cycle Out_Valid=0, Occupancy=0, Out_Ctrl=CTRL_BUBBLE (set to 0x5A5A), Out_Data unchanged, Beat_Count unchanged, incoming beat never appears.
- SKID=0 instance: Out_Ready=0 with one beat held -> In_Ready=0 combinationally. Out_Ready=1 with In_Valid=1 -> In_Ready=1 the same cycle, replace-in-place, Occupancy stays 1.
- Counter saturation: CNT_W=4, 20 transfers -> Beat_Count stops at 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Purpose: generic pipeline stage register carrying a control and a data bundle over valid/ready.
// Latency: 1 cycle from in_fire to Out_Valid; sustains 1 beat/cycle while Out_Ready=1.
// Backpressure: SKID=1 absorbs one extra beat and drives a registered In_Ready; SKID=0 holds one beat with In_Ready = !Out_Valid | Out_Ready.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int unsigned       SKID        = 1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  Beat_Count
);

  // One beat as it travels between stages: controls on top, data below.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_n;
  beat_t            main_q;
  beat_t            main_n;
  beat_t            skid_q;
  beat_t            skid_n;
  beat_t            in_beat;
  logic             in_ready_q;
  logic             in_ready_n;
  logic             in_ready_int;
  logic             out_valid_int;
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] beat_cnt_q;

  assign in_beat       = {In_Ctrl, In_Data};
  assign out_valid_int = (state_q != ST_EMPTY);

  // With the skid entry the ready is a flop, so no path runs from Out_Ready to In_Ready.
  assign in_ready_int  = (SKID != 0) ? in_ready_q : (!out_valid_int | Out_Ready);

  assign in_fire  = In_Valid & in_ready_int;
  assign out_fire = out_valid_int & Out_Ready;

  // Next-state, next-entry and next-ready decode; Flush overrides every transfer.
  always_comb begin
    state_n = state_q;
    main_n  = main_q;
    skid_n  = skid_q;
    if (Flush) begin
      // Incoming beat is dropped; main keeps its data so Out_Data stays put.
      state_n = ST_EMPTY;
      skid_n  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_n  = in_beat;
            state_n = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            // Only reachable with the skid entry: downstream stalled but we still accepted.
            if (SKID != 0) begin
              skid_n  = in_beat;
              state_n = ST_TWO;
            end
          end else if (in_fire && out_fire) begin
            main_n = in_beat;
          end else if (out_fire) begin
            state_n = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_n  = skid_q;
            skid_n  = '0;
            state_n = ST_ONE;
          end
        end
        default: begin
          state_n = ST_EMPTY;
          skid_n  = '0;
        end
      endcase
    end
    in_ready_n = (state_n != ST_TWO);
  end

  // State, beat storage and registered ready; reset empties the stage and opens the input.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_n;
      main_q     <= main_n;
      skid_q     <= skid_n;
      in_ready_q <= in_ready_n;
    end
  end

  // Debug beat counter: counts downstream transfers (even one coinciding with Flush), saturates.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      beat_cnt_q <= '0;
    end else if (out_fire && (beat_cnt_q != {CNT_W{1'b1}})) begin
      beat_cnt_q <= beat_cnt_q + CNT_W'(1);
    end
  end

  assign In_Ready   = in_ready_int;
  assign Out_Valid  = out_valid_int;
  // Empty stage presents no-op controls so downstream enables stay inert.
  assign Out_Ctrl   = out_valid_int ? main_q.ctrl : CTRL_BUBBLE;
  assign Out_Data   = main_q.data;
  assign Occupancy  = state_q;
  assign Beat_Count = beat_cnt_q;

endmodule
